instcache: RTL and testbench

INSTCACHE -- requirements
Module: instcache

---
 rtl/instcache_pkg.sv | 32 +++
 rtl/instcache_axi_if.sv | 46 ++++
 rtl/instcache_ram.sv | 26 ++
 rtl/instcache.sv | 234 +++++++++++++++++++++++
 tb/tb_instcache.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instcache_pkg.sv
// Shared definitions for the instruction cache: FSM encodings, fixed AXI
// read-channel attributes and a compile-time log2 helper.
package instcache_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_AR   = 2'b01,
        S_R    = 2'b11
    } state_e;

    // 4-byte beats, incrementing bursts, normal non-cacheable bufferable
    localparam logic [2:0] AXI_ARSIZE       = 3'b010;
    localparam logic [1:0] AXI_ARBURST_INCR = 2'b01;
    localparam logic [3:0] AXI_ARCACHE      = 4'b0011;

    // Ceiling log2; returns 0 for 0 and 1
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        int unsigned v;
        r = 0;
        if (value <= 1) begin
            return 0;
        end
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/instcache_axi_if.sv
// AXI4 read-address and read-data channels used by the cache line fill.
interface instcache_axi_if #(
    parameter int unsigned ID_WIDTH     = 1,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ARUSER_WIDTH = 1,
    parameter int unsigned RUSER_WIDTH  = 4
);
    logic [ID_WIDTH-1:0]     ARID;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [7:0]              ARLEN;
    logic [2:0]              ARSIZE;
    logic [1:0]              ARBURST;
    logic                    ARLOCK;
    logic [3:0]              ARCACHE;
    logic [2:0]              ARPROT;
    logic [3:0]              ARQOS;
    logic [ARUSER_WIDTH-1:0] ARUSER;
    logic                    ARVALID;
    logic                    ARREADY;

    logic [ID_WIDTH-1:0]     RID;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RLAST;
    logic [RUSER_WIDTH-1:0]  RUSER;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARUSER,
        output ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RUSER, RVALID,
        output RREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARUSER,
        input  ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RUSER, RVALID,
        input  RREADY
    );

endinterface

// File: rtl/instcache_ram.sv
// Single-port 32-bit data array with byte write enables and registered read.
// Contents are not reset.
module instcache_ram #(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = 9
) (
    input  logic          CLK,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Byte-masked write and read-before-write registered output
    always_ff @(posedge CLK) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/instcache.sv
// Direct-mapped instruction cache with whole-line AXI4 burst refill.
// Hits return one word per cycle with one cycle latency; a miss fetches the
// full line starting at its first word.
module instcache
    import instcache_pkg::*;
#(
    parameter int unsigned C_M_AXI_THREAD_ID_WIDTH = 1,
    parameter int unsigned C_M_AXI_ADDR_WIDTH      = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH      = 32,
    parameter int unsigned C_M_AXI_ARUSER_WIDTH    = 1,
    parameter int unsigned C_M_AXI_RUSER_WIDTH     = 4,
    parameter int unsigned LINE_WORDS              = 32,
    parameter int unsigned NUM_LINES               = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        STALL,
    input  logic        FLUSH,
    input  logic        INVALIDATE,
    input  logic [31:0] ADDR,
    input  logic        RDEN,
    output logic [31:0] OADDR,
    output logic [31:0] DOUT,
    output logic        VALID,
    output logic        LOADING,
    output logic        ERROR,
    instcache_axi_if.master m_axi
);

    localparam int unsigned OFF_W     = clog2(LINE_WORDS);
    localparam int unsigned IDX_W     = clog2(NUM_LINES);
    localparam int unsigned IDX_S     = (IDX_W == 0) ? 1 : IDX_W;
    localparam int unsigned TAG_W     = 30 - OFF_W - IDX_W;
    localparam int unsigned RAM_DEPTH = NUM_LINES * LINE_WORDS;
    localparam int unsigned RAM_AW    = clog2(RAM_DEPTH);
    localparam logic [31:0] LINE_MASK = (32'd1 << (OFF_W + 2)) - 32'd1;

    state_e state_q, state_d;

    logic [31:0]      held_addr_q;
    logic             held_rden_q;
    logic [31:0]      addr;
    logic             rden;
    logic [OFF_W-1:0] offset;
    logic [IDX_S-1:0] index;
    logic [TAG_W-1:0] tag;
    logic             hit;

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q [NUM_LINES];

    logic [31:0]      araddr_q;
    logic             arvalid_q;
    logic [IDX_S-1:0] fill_index_q;
    logic [TAG_W-1:0] fill_tag_q;
    logic [OFF_W-1:0] fill_cnt_q;
    logic             err_seen_q;
    logic             inval_seen_q;
    logic             start_fill;
    logic             beat;
    logic             fill_done;
    logic             beat_err;

    logic [31:0] oaddr_q;
    logic        valid_out_q;
    logic        error_q;

    logic [RAM_AW-1:0] ram_addr;
    logic [3:0]        ram_we;
    logic [31:0]       ram_wdata;

    // Effective request: STALL replays the held request
    always_comb begin
        addr   = STALL ? held_addr_q : ADDR;
        rden   = STALL ? held_rden_q : RDEN;
        offset = OFF_W'(addr >> 2);
        index  = IDX_S'(addr >> (OFF_W + 2)) & IDX_S'(NUM_LINES - 1);
        tag    = TAG_W'(addr >> (OFF_W + IDX_W + 2));
        // Lookups only count while idle; a busy cache never reports a hit
        hit    = valid_q[index] && (tag_q[index] == tag) && (state_q == S_IDLE);
    end

    always_comb begin
        start_fill = (state_q == S_IDLE) && rden && !hit;
        beat       = (state_q == S_R) && m_axi.RVALID;
        fill_done  = beat && m_axi.RLAST;
        beat_err   = m_axi.RRESP != 2'b00;
    end

    // Held request register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            held_addr_q <= '0;
            held_rden_q <= 1'b0;
        end else if (!STALL) begin
            held_addr_q <= FLUSH ? '0 : ADDR;
            held_rden_q <= FLUSH ? 1'b0 : RDEN;
        end
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (rden && !hit) state_d = S_AR;
            S_AR:    if (m_axi.ARREADY) state_d = S_R;
            S_R:     if (m_axi.RVALID && m_axi.RLAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Fill bookkeeping: AR request, beat counter and error/invalidate sticky flags
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            fill_index_q <= '0;
            fill_tag_q   <= '0;
            fill_cnt_q   <= '0;
            err_seen_q   <= 1'b0;
            inval_seen_q <= 1'b0;
        end else begin
            if (start_fill) begin
                araddr_q     <= addr & ~LINE_MASK;
                arvalid_q    <= 1'b1;
                fill_index_q <= index;
                fill_tag_q   <= tag;
                fill_cnt_q   <= '0;
                err_seen_q   <= 1'b0;
                inval_seen_q <= INVALIDATE;
            end else begin
                if ((state_q == S_AR) && m_axi.ARREADY) begin
                    arvalid_q <= 1'b0;
                end
                if ((state_q != S_IDLE) && INVALIDATE) begin
                    inval_seen_q <= 1'b1;
                end
                if (beat) begin
                    // Power-of-two line length, so the counter wraps to 0 after the last beat
                    fill_cnt_q <= fill_cnt_q + OFF_W'(1);
                    if (beat_err) begin
                        err_seen_q <= 1'b1;
                    end
                end
            end
        end
    end

    // Line valid bits and tags; INVALIDATE overrides a same-cycle validation
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_q <= '0;
            for (int i = 0; i < int'(NUM_LINES); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            if (fill_done) begin
                tag_q[fill_index_q]   <= fill_tag_q;
                // The data was overwritten, so a failed fill leaves the line invalid
                valid_q[fill_index_q] <= !err_seen_q && !beat_err && !inval_seen_q;
            end
            if (INVALIDATE) begin
                valid_q <= '0;
            end
        end
    end

    // Registered fetch outputs and the one-cycle fill error pulse
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            oaddr_q     <= '0;
            valid_out_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            oaddr_q     <= addr;
            valid_out_q <= rden && hit;
            error_q     <= fill_done && (err_seen_q || beat_err);
        end
    end

    // Data array addressing: lookup while idle, fill position otherwise
    always_comb begin
        if (state_q == S_IDLE) begin
            ram_addr = RAM_AW'(32'(index) * LINE_WORDS + 32'(offset));
        end else begin
            ram_addr = RAM_AW'(32'(fill_index_q) * LINE_WORDS + 32'(fill_cnt_q));
        end
        ram_we    = {4{beat}};
        ram_wdata = m_axi.RDATA[31:0];
    end

    instcache_ram #(
        .DEPTH (RAM_DEPTH),
        .AW    (RAM_AW)
    ) u_ram (
        .CLK   (CLK),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (DOUT)
    );

    assign OADDR   = oaddr_q;
    assign VALID   = valid_out_q;
    assign ERROR   = error_q;
    assign LOADING = rden && !hit;

    assign m_axi.ARID    = '0;
    assign m_axi.ARADDR  = C_M_AXI_ADDR_WIDTH'(araddr_q);
    assign m_axi.ARLEN   = 8'(LINE_WORDS - 1);
    assign m_axi.ARSIZE  = AXI_ARSIZE;
    assign m_axi.ARBURST = AXI_ARBURST_INCR;
    assign m_axi.ARLOCK  = 1'b0;
    assign m_axi.ARCACHE = AXI_ARCACHE;
    assign m_axi.ARPROT  = '0;
    assign m_axi.ARQOS   = '0;
    assign m_axi.ARUSER  = '0;
    assign m_axi.ARVALID = arvalid_q;
    assign m_axi.RREADY  = 1'b1;

    // Read ID and user bits carry nothing the cache needs
    logic unused_r;
    assign unused_r = ^{m_axi.RID, m_axi.RUSER};

endmodule

// File: tb/tb_instcache.sv
// Directed bench for instcache: a cycle-level reference model of the cache
// behaviour checks every output each cycle, and a memory slave serves bursts.
module tb_instcache;

    localparam int unsigned LW         = 32;
    localparam int unsigned NL         = 16;
    localparam logic [31:0] LINE_BYTES = LW * 4;

    logic        CLK;
    logic        RST_N;
    logic        STALL;
    logic        FLUSH;
    logic        INVALIDATE;
    logic [31:0] ADDR;
    logic        RDEN;
    logic [31:0] OADDR;
    logic [31:0] DOUT;
    logic        VALID;
    logic        LOADING;
    logic        ERROR;

    int tests = 0;
    int fails = 0;

    instcache_axi_if #(
        .ID_WIDTH     (1),
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .ARUSER_WIDTH (1),
        .RUSER_WIDTH  (4)
    ) axi ();

    instcache #(
        .C_M_AXI_THREAD_ID_WIDTH (1),
        .C_M_AXI_ADDR_WIDTH      (32),
        .C_M_AXI_DATA_WIDTH      (32),
        .C_M_AXI_ARUSER_WIDTH    (1),
        .C_M_AXI_RUSER_WIDTH     (4),
        .LINE_WORDS              (LW),
        .NUM_LINES               (NL)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .STALL      (STALL),
        .FLUSH      (FLUSH),
        .INVALIDATE (INVALIDATE),
        .ADDR       (ADDR),
        .RDEN       (RDEN),
        .OADDR      (OADDR),
        .DOUT       (DOUT),
        .VALID      (VALID),
        .LOADING    (LOADING),
        .ERROR      (ERROR),
        .m_axi      (axi)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory image: upper half is the word address, lower half its complement
    function automatic logic [31:0] word_data(input logic [31:0] a);
        logic [15:0] lo;
        lo = a[15:0] & 16'hFFFC;
        return {lo, ~lo};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory slave ----------------
    int          err_beat = -1;
    int          s_beat   = 0;
    int          s_phase  = 0;
    bit          s_gapped = 1'b0;
    logic [31:0] s_base   = '0;

    task automatic drive_beat();
        axi.RVALID = 1'b1;
        axi.RDATA  = word_data(s_base + 32'(4 * s_beat));
        axi.RRESP  = (s_beat == err_beat) ? 2'b10 : 2'b00;
        axi.RLAST  = (s_beat == int'(LW) - 1);
    endtask

    initial begin
        axi.ARREADY = 1'b0;
        axi.RVALID  = 1'b0;
        axi.RLAST   = 1'b0;
        axi.RDATA   = '0;
        axi.RRESP   = 2'b00;
        axi.RID     = '0;
        axi.RUSER   = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (!RST_N) begin
                axi.ARREADY = 1'b0;
                axi.RVALID  = 1'b0;
                axi.RLAST   = 1'b0;
                s_phase     = 0;
            end else if (s_phase == 0) begin
                if (axi.ARVALID) begin
                    axi.ARREADY = 1'b1;
                    s_base      = axi.ARADDR;
                    s_phase     = 1;
                end
            end else if (s_phase == 1) begin
                axi.ARREADY = 1'b0;
                s_beat      = 0;
                s_gapped    = 1'b0;
                drive_beat();
                s_phase     = 2;
            end else begin
                if (axi.RVALID) s_beat++;
                if (s_beat == int'(LW)) begin
                    axi.RVALID = 1'b0;
                    axi.RLAST  = 1'b0;
                    s_phase    = 0;
                end else if (s_beat == 7 && !s_gapped) begin
                    // One idle cycle mid-burst
                    axi.RVALID = 1'b0;
                    axi.RLAST  = 1'b0;
                    s_gapped   = 1'b1;
                end else begin
                    drive_beat();
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] m_held_addr;
    logic        m_held_rden;
    bit          m_valid [NL];
    logic [31:0] m_tag   [NL];
    int          m_phase;      // 0 lookup, 1 address request out, 2 receiving line
    logic [31:0] m_fill_base;
    int          m_fill_idx;
    logic [31:0] m_fill_tag;
    bit          m_err;
    bit          m_inval;
    logic        exp_valid;
    logic [31:0] exp_oaddr;
    logic        exp_error;
    logic        exp_arvalid;

    task automatic model_reset();
        m_held_addr = '0;
        m_held_rden = 1'b0;
        for (int i = 0; i < int'(NL); i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
        end
        m_phase     = 0;
        m_fill_base = '0;
        m_err       = 1'b0;
        m_inval     = 1'b0;
        exp_valid   = 1'b0;
        exp_oaddr   = '0;
        exp_error   = 1'b0;
        exp_arvalid = 1'b0;
    endtask

    initial begin
        logic [31:0] eff_addr;
        logic        eff_rden;
        int          idx;
        logic [31:0] tg;
        bit          hit;
        logic        n_valid;
        logic        n_error;
        model_reset();
        forever begin
            @(negedge CLK);
            if (!RST_N) model_reset();
            eff_addr = STALL ? m_held_addr : ADDR;
            eff_rden = STALL ? m_held_rden : RDEN;
            idx      = int'((eff_addr / LINE_BYTES) % NL);
            tg       = eff_addr / (LINE_BYTES * NL);
            hit      = (m_phase == 0) && m_valid[idx] && (m_tag[idx] == tg);

            check("VALID", VALID, exp_valid);
            check("OADDR", OADDR, exp_oaddr);
            check("ERROR", ERROR, exp_error);
            check("ARVALID", axi.ARVALID, exp_arvalid);
            check("LOADING", LOADING, eff_rden && !hit);
            if (exp_arvalid) check("ARADDR", axi.ARADDR, m_fill_base);
            if (exp_valid) check("DOUT", DOUT, word_data(exp_oaddr));

            if (RST_N) begin
                n_valid = eff_rden && hit;
                n_error = 1'b0;
                if (m_phase == 0) begin
                    if (eff_rden && !hit) begin
                        m_phase     = 1;
                        m_fill_base = eff_addr & ~(LINE_BYTES - 1);
                        m_fill_idx  = idx;
                        m_fill_tag  = tg;
                        m_err       = 1'b0;
                        m_inval     = INVALIDATE;
                        exp_arvalid = 1'b1;
                    end
                end else if (m_phase == 1) begin
                    if (INVALIDATE) m_inval = 1'b1;
                    if (axi.ARREADY) begin
                        m_phase     = 2;
                        exp_arvalid = 1'b0;
                    end
                end else begin
                    if (INVALIDATE) m_inval = 1'b1;
                    if (axi.RVALID) begin
                        if (axi.RRESP != 2'b00) m_err = 1'b1;
                        if (axi.RLAST) begin
                            m_phase              = 0;
                            m_tag[m_fill_idx]    = m_fill_tag;
                            m_valid[m_fill_idx]  = !m_err && !m_inval;
                            n_error              = m_err;
                        end
                    end
                end
                if (INVALIDATE) begin
                    for (int i = 0; i < int'(NL); i++) m_valid[i] = 1'b0;
                end
                if (!STALL) begin
                    m_held_addr = FLUSH ? 32'h0 : ADDR;
                    m_held_rden = FLUSH ? 1'b0 : RDEN;
                end
                exp_valid = n_valid;
                exp_oaddr = eff_addr;
                exp_error = n_error;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ar(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            if (axi.ARVALID) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            if (VALID) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_error(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            if (ERROR) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    initial begin
        int  ar_during;
        bit  reached;
        RST_N      = 1'b1;
        STALL      = 1'b0;
        FLUSH      = 1'b0;
        INVALIDATE = 1'b0;
        RDEN       = 1'b0;
        ADDR       = '0;
        #1 RST_N = 1'b0;
        step();
        step();
        check("rst_arvalid", axi.ARVALID, 32'd0);
        check("rst_valid", VALID, 32'd0);
        check("rst_oaddr", OADDR, 32'd0);
        check("rst_error", ERROR, 32'd0);
        RST_N = 1'b1;
        step();

        check("arlen", axi.ARLEN, 32'd31);
        check("arsize", axi.ARSIZE, 32'd2);
        check("arburst", axi.ARBURST, 32'd1);
        check("arcache", axi.ARCACHE, 32'd3);
        check("ar_zero_fields", {axi.ARID, axi.ARLOCK, axi.ARPROT, axi.ARQOS, axi.ARUSER}, 32'd0);
        check("rready", axi.RREADY, 32'd1);

        // Cold miss on 0x1004
        ADDR = 32'h0000_1004;
        RDEN = 1'b1;
        wait_ar("ar_1004");
        check("araddr_1000", axi.ARADDR, 32'h0000_1000);
        check("loading_miss", LOADING, 32'd1);
        wait_valid("valid_1004");
        check("dout_1004", DOUT, 32'h1004_EFFB);
        check("oaddr_1004", OADDR, 32'h0000_1004);

        // Streaming hits across the whole line
        ar_during = 0;
        for (int i = 0; i < int'(LW); i++) begin
            ADDR = 32'h0000_1000 + 32'(4 * i);
            step();
            if (axi.ARVALID) ar_during++;
        end
        check("no_ar_on_hits", 32'(ar_during), 32'd0);

        // Conflict on index 0 with a different tag, then back
        ADDR = 32'h0000_1800;
        wait_ar("ar_1800");
        check("araddr_1800", axi.ARADDR, 32'h0000_1800);
        wait_valid("valid_1800");
        check("dout_1800", DOUT, 32'h1800_E7FF);
        ADDR = 32'h0000_1000;
        wait_ar("ar_1000_again");
        check("araddr_1000_again", axi.ARADDR, 32'h0000_1000);
        wait_valid("valid_1000_again");

        // STALL replays the held request; FLUSH clears it
        ADDR = 32'h0000_1008;
        step();
        STALL = 1'b1;
        ADDR  = 32'hDEAD_0000;
        RDEN  = 1'b0;
        step();
        check("stall_valid", VALID, 32'd1);
        check("stall_oaddr", OADDR, 32'h0000_1008);
        STALL = 1'b0;
        FLUSH = 1'b1;
        ADDR  = 32'h0000_1010;
        RDEN  = 1'b1;
        step();
        FLUSH = 1'b0;
        STALL = 1'b1;
        step();
        step();
        check("flush_valid", VALID, 32'd0);
        check("flush_loading", LOADING, 32'd0);
        STALL = 1'b0;
        RDEN  = 1'b0;
        step();

        // INVALIDATE mid-burst: line not validated, request re-fetches
        ADDR = 32'h0000_2000;
        RDEN = 1'b1;
        wait_ar("ar_2000");
        repeat (6) step();
        INVALIDATE = 1'b1;
        step();
        INVALIDATE = 1'b0;
        wait_ar("ar_2000_after_inval");
        check("araddr_2000", axi.ARADDR, 32'h0000_2000);
        wait_valid("valid_2000");

        // Error response on beat 5
        err_beat = 5;
        ADDR     = 32'h0000_3000;
        wait_ar("ar_3000");
        RDEN = 1'b0;
        wait_error("error_seen");
        step();
        check("error_one_cycle", ERROR, 32'd0);
        err_beat = -1;
        RDEN     = 1'b1;
        wait_ar("ar_3000_retry");
        wait_valid("valid_3000");
        check("dout_3000", DOUT, 32'h3000_CFFF);

        // Reset during the data phase
        ADDR = 32'h0000_4000;
        wait_ar("ar_4000");
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            step();
            if (s_phase == 2 && s_beat == 10) reached = 1'b1;
        end
        check("reached_beat10", 32'(reached), 32'd1);
        RST_N = 1'b0;
        RDEN  = 1'b0;
        #1;
        check("rst_mid_arvalid", axi.ARVALID, 32'd0);
        check("rst_mid_valid", VALID, 32'd0);
        step();
        step();
        RST_N = 1'b1;
        step();
        ADDR = 32'h0000_4000;
        RDEN = 1'b1;
        wait_ar("ar_4000_after_reset");
        check("araddr_4000", axi.ARADDR, 32'h0000_4000);
        wait_valid("valid_4000");
        check("dout_4000", DOUT, 32'h4000_BFFF);

        RDEN = 1'b0;
        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
